checkpoint_regfile: RTL and testbench

CHECKPOINT_REGFILE -- requirements
Module: checkpoint_regfile

---
 rtl/checkpoint_regfile.sv | 137 +++++++++++++
 tb/tb_checkpoint_regfile.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/checkpoint_regfile.sv
// Register file with a rename alias table and a small set of alias-table checkpoints
// for branch-mispredict recovery. Reads are combinational with rename/commit bypass.
module checkpoint_regfile #(
    parameter  int XLEN  = 32,
    parameter  int NREG  = 32,
    parameter  int TAGW  = 4,
    parameter  int NRD   = 2,
    parameter  int NCKPT = 4,
    localparam int RW    = $clog2(NREG),
    localparam int CW    = $clog2(NCKPT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic [NRD*RW-1:0]    rd_idx,
    output logic [NRD*TAGW-1:0]  rd_tag,
    output logic [NRD*XLEN-1:0]  rd_val,
    input  logic                 ren_en,
    input  logic [RW-1:0]        ren_reg,
    input  logic [TAGW-1:0]      ren_tag,
    input  logic                 cmt_en,
    input  logic [RW-1:0]        cmt_reg,
    input  logic [TAGW-1:0]      cmt_tag,
    input  logic [XLEN-1:0]      cmt_val,
    input  logic                 ck_save,
    output logic [CW-1:0]        ck_id,
    output logic                 ck_full,
    input  logic                 ck_release,
    input  logic [CW-1:0]        ck_rel_id,
    input  logic                 ck_restore,
    input  logic [CW-1:0]        ck_res_id,
    input  logic [NCKPT-1:0]     ck_kill_mask,
    input  logic                 flush_all
);

    logic [XLEN-1:0] reg_q     [NREG];
    logic [XLEN-1:0] reg_d     [NREG];
    logic [TAGW-1:0] alias_q   [NREG];
    logic [TAGW-1:0] alias_d   [NREG];
    logic [TAGW-1:0] alias_cc  [NREG];
    logic [TAGW-1:0] alias_post[NREG];
    logic [TAGW-1:0] snap_q    [NCKPT][NREG];
    logic [TAGW-1:0] snap_d    [NCKPT][NREG];
    logic [TAGW-1:0] snap_cc   [NCKPT][NREG];
    logic [NCKPT-1:0] valid_q;
    logic [NCKPT-1:0] valid_d;

    logic cmt_fire;
    logic ren_fire;

    assign cmt_fire = cmt_en && (cmt_reg != '0);
    assign ren_fire = ren_en && (ren_reg != '0);

    // A commit only bypasses a reader whose current alias is the retiring tag.
    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [RW-1:0]   idx;
        logic [TAGW-1:0] alias_p;
        logic            hit_cmt;

        assign idx     = rd_idx[p*RW +: RW];
        assign alias_p = (ren_en && (ren_reg == idx) && (idx != '0)) ? ren_tag : alias_q[idx];
        assign hit_cmt = cmt_en && (cmt_reg == idx) && (alias_p == cmt_tag);
        assign rd_tag[p*TAGW +: TAGW] = ((idx == '0) || hit_cmt) ? '0 : alias_p;
        assign rd_val[p*XLEN +: XLEN] = (idx == '0) ? '0 : (hit_cmt ? cmt_val : reg_q[idx]);
    end

    assign ck_full = &valid_q;

    always_comb begin
        ck_id = '0;
        for (int k = NCKPT - 1; k >= 0; k--) begin
            if (!valid_q[k]) ck_id = CW'(k);
        end
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        reg_d = reg_q;
        if (cmt_fire) reg_d[cmt_reg] = cmt_val;

        for (int i = 0; i < NREG; i++) begin
            alias_cc[i] = alias_q[i];
            if (cmt_fire && (cmt_reg == RW'(i)) && (alias_q[i] == cmt_tag)) alias_cc[i] = '0;
            alias_post[i] = alias_cc[i];
            if (ren_fire && (ren_reg == RW'(i))) alias_post[i] = ren_tag;
        end

        // Retired tags are scrubbed from snapshots so a later restore cannot revive them.
        for (int k = 0; k < NCKPT; k++) begin
            for (int i = 0; i < NREG; i++) begin
                snap_cc[k][i] = snap_q[k][i];
                if (cmt_fire && (cmt_reg == RW'(i)) && (snap_q[k][i] == cmt_tag)) snap_cc[k][i] = '0;
            end
        end

        snap_d  = snap_cc;
        alias_d = alias_post;
        valid_d = valid_q;

        if (flush_all) begin
            alias_d = '{default: '0};
            valid_d = '0;
        end else if (ck_restore) begin
            alias_d = alias_cc;
            if (valid_q[ck_res_id]) begin
                alias_d            = snap_cc[ck_res_id];
                valid_d            = valid_q & ~ck_kill_mask;
                valid_d[ck_res_id] = 1'b0;
            end
        end else begin
            if (ck_release) valid_d[ck_rel_id] = 1'b0;
            if (ck_save && !ck_full) begin
                valid_d[ck_id] = 1'b1;
                snap_d[ck_id]  = alias_post;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_q   <= '{default: '0};
            alias_q <= '{default: '0};
            valid_q <= '0;
        end else if (rdy) begin
            reg_q   <= reg_d;
            alias_q <= alias_d;
            valid_q <= valid_d;
        end
    end

    // NOTE: snapshot storage is not reset; its contents only matter once the valid bit is set.
    always_ff @(posedge clk) begin
        if (!rst && rdy) snap_q <= snap_d;
    end

endmodule

// File: tb/tb_checkpoint_regfile.sv
// Directed bench for checkpoint_regfile: rename/commit bypass, checkpoints, flush, hold and x0.
module tb_checkpoint_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [9:0]  rd_idx;
    logic [7:0]  rd_tag;
    logic [63:0] rd_val;
    logic        ren_en;
    logic [4:0]  ren_reg;
    logic [3:0]  ren_tag;
    logic        cmt_en;
    logic [4:0]  cmt_reg;
    logic [3:0]  cmt_tag;
    logic [31:0] cmt_val;
    logic        ck_save;
    logic [1:0]  ck_id;
    logic        ck_full;
    logic        ck_release;
    logic [1:0]  ck_rel_id;
    logic        ck_restore;
    logic [1:0]  ck_res_id;
    logic [3:0]  ck_kill_mask;
    logic        flush_all;

    int n_tests = 0;
    int n_fail  = 0;

    checkpoint_regfile dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .rd_idx(rd_idx), .rd_tag(rd_tag), .rd_val(rd_val),
        .ren_en(ren_en), .ren_reg(ren_reg), .ren_tag(ren_tag),
        .cmt_en(cmt_en), .cmt_reg(cmt_reg), .cmt_tag(cmt_tag), .cmt_val(cmt_val),
        .ck_save(ck_save), .ck_id(ck_id), .ck_full(ck_full),
        .ck_release(ck_release), .ck_rel_id(ck_rel_id),
        .ck_restore(ck_restore), .ck_res_id(ck_res_id), .ck_kill_mask(ck_kill_mask),
        .flush_all(flush_all)
    );

    always #5 clk = ~clk;

    // Producer-side protocol check: never save while no checkpoint is free.
    always @(posedge clk) begin
        if (!rst && rdy && ck_save && ck_full) begin
            $display("FAIL proto_save_when_full: ck_save=1 with ck_full=1, required no save");
            n_fail++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "timeout");
    end

    task automatic clr_req();
        ren_en = 0; ren_reg = 0; ren_tag = 0;
        cmt_en = 0; cmt_reg = 0; cmt_tag = 0; cmt_val = 0;
        ck_save = 0; ck_release = 0; ck_rel_id = 0;
        ck_restore = 0; ck_res_id = 0; ck_kill_mask = 0; flush_all = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] p0, input logic [4:0] p1);
        rd_idx = {p1, p0};
        #1;
    endtask

    task automatic test_reset();
        rst = 0; rdy = 1; clr_req();
        ren_en = 1; ren_reg = 5; ren_tag = 3;
        cmt_en = 1; cmt_reg = 6; cmt_tag = 0; cmt_val = 32'h55;
        ck_save = 1;
        tick(); clr_req(); set_rd(5, 6);
        n_tests++;
        if (rd_tag[3:0] !== 4'd3) begin $display("FAIL pre_reset_tag: got %0d, required 3", rd_tag[3:0]); n_fail++; end
        n_tests++;
        if (rd_val[63:32] !== 32'h55) begin $display("FAIL pre_reset_val: got %h, required 55", rd_val[63:32]); n_fail++; end
        rst = 1; rdy = 0;
        ren_en = 1; ren_reg = 5; ren_tag = 9;
        cmt_en = 1; cmt_reg = 6; cmt_tag = 0; cmt_val = 32'h66;
        ck_save = 1;
        tick(); rst = 0; rdy = 1; clr_req(); set_rd(5, 6);
        n_tests++;
        if (rd_tag !== 8'h00) begin $display("FAIL reset_tags: got %h, required 00", rd_tag); n_fail++; end
        n_tests++;
        if (rd_val !== 64'h0) begin $display("FAIL reset_vals: got %h, required 0", rd_val); n_fail++; end
        n_tests++;
        if (ck_full !== 1'b0 || ck_id !== 2'd0) begin
            $display("FAIL reset_ck: got full=%0b id=%0d, required full=0 id=0", ck_full, ck_id); n_fail++;
        end
    endtask

    task automatic test_rename_commit();
        ren_en = 1; ren_reg = 5; ren_tag = 3; set_rd(5, 0);
        n_tests++;
        if (rd_tag[3:0] !== 4'd3) begin $display("FAIL ren_bypass_tag: got %0d, required 3", rd_tag[3:0]); n_fail++; end
        tick(); clr_req(); set_rd(5, 0);
        n_tests++;
        if (rd_tag[3:0] !== 4'd3) begin $display("FAIL ren_next_tag: got %0d, required 3", rd_tag[3:0]); n_fail++; end
        cmt_en = 1; cmt_reg = 5; cmt_tag = 3; cmt_val = 32'hAB; #1;
        n_tests++;
        if (rd_tag[3:0] !== 4'd0 || rd_val[31:0] !== 32'hAB) begin
            $display("FAIL cmt_bypass: got tag=%0d val=%h, required tag=0 val=ab", rd_tag[3:0], rd_val[31:0]); n_fail++;
        end
        tick(); clr_req(); set_rd(5, 0);
        n_tests++;
        if (rd_tag[3:0] !== 4'd0 || rd_val[31:0] !== 32'hAB) begin
            $display("FAIL cmt_after: got tag=%0d val=%h, required tag=0 val=ab", rd_tag[3:0], rd_val[31:0]); n_fail++;
        end
    endtask

    task automatic test_rename_wins();
        ren_en = 1; ren_reg = 7; ren_tag = 2;
        cmt_en = 1; cmt_reg = 7; cmt_tag = 1; cmt_val = 32'h77;
        set_rd(0, 7);
        n_tests++;
        if (rd_tag[7:4] !== 4'd2) begin $display("FAIL ren_cmt_same_tag: got %0d, required 2", rd_tag[7:4]); n_fail++; end
        tick(); clr_req(); set_rd(0, 7);
        n_tests++;
        if (rd_tag[7:4] !== 4'd2 || rd_val[63:32] !== 32'h77) begin
            $display("FAIL ren_wins_after: got tag=%0d val=%h, required tag=2 val=77", rd_tag[7:4], rd_val[63:32]); n_fail++;
        end
    endtask

    task automatic test_checkpoint_restore();
        ren_en = 1; ren_reg = 1; ren_tag = 4; tick(); clr_req();
        ck_save = 1; #1;
        n_tests++;
        if (ck_id !== 2'd0) begin $display("FAIL save_id0: got %0d, required 0", ck_id); n_fail++; end
        tick(); clr_req();
        ren_en = 1; ren_reg = 1; ren_tag = 6; tick(); clr_req(); set_rd(1, 7);
        n_tests++;
        if (rd_tag[3:0] !== 4'd6) begin $display("FAIL ren_after_save: got %0d, required 6", rd_tag[3:0]); n_fail++; end
        ck_restore = 1; ck_res_id = 0; tick(); clr_req(); set_rd(1, 7);
        n_tests++;
        if (rd_tag[3:0] !== 4'd4 || rd_tag[7:4] !== 4'd2) begin
            $display("FAIL restore_tags: got x1=%0d x7=%0d, required x1=4 x7=2", rd_tag[3:0], rd_tag[7:4]); n_fail++;
        end
        n_tests++;
        if (ck_id !== 2'd0 || ck_full !== 1'b0) begin
            $display("FAIL restore_frees: got id=%0d full=%0b, required id=0 full=0", ck_id, ck_full); n_fail++;
        end
        // Second pass: the tag retires while only the snapshot still holds it.
        ck_save = 1; tick(); clr_req();
        ren_en = 1; ren_reg = 1; ren_tag = 6; tick(); clr_req();
        cmt_en = 1; cmt_reg = 1; cmt_tag = 4; cmt_val = 32'h44; set_rd(1, 0);
        n_tests++;
        if (rd_tag[3:0] !== 4'd6 || rd_val[31:0] !== 32'h0) begin
            $display("FAIL cmt_no_bypass: got tag=%0d val=%h, required tag=6 val=0", rd_tag[3:0], rd_val[31:0]); n_fail++;
        end
        tick(); clr_req();
        ck_restore = 1; ck_res_id = 0; tick(); clr_req(); set_rd(1, 0);
        n_tests++;
        if (rd_tag[3:0] !== 4'd0 || rd_val[31:0] !== 32'h44) begin
            $display("FAIL restore_scrubbed: got tag=%0d val=%h, required tag=0 val=44", rd_tag[3:0], rd_val[31:0]); n_fail++;
        end
    endtask

    task automatic test_ck_alloc();
        for (int i = 0; i < 4; i++) begin
            ck_save = 1; #1;
            n_tests++;
            if (ck_id !== 2'(i)) begin $display("FAIL alloc_id%0d: got %0d, required %0d", i, ck_id, i); n_fail++; end
            tick(); clr_req();
        end
        #1;
        n_tests++;
        if (ck_full !== 1'b1 || ck_id !== 2'd0) begin
            $display("FAIL alloc_full: got full=%0b id=%0d, required full=1 id=0", ck_full, ck_id); n_fail++;
        end
        ck_release = 1; ck_rel_id = 2; tick(); clr_req();
        n_tests++;
        if (ck_full !== 1'b0 || ck_id !== 2'd2) begin
            $display("FAIL release2: got full=%0b id=%0d, required full=0 id=2", ck_full, ck_id); n_fail++;
        end
        ck_restore = 1; ck_res_id = 0; ck_kill_mask = 4'b1010; tick(); clr_req();
        n_tests++;
        if (ck_full !== 1'b0 || ck_id !== 2'd0) begin
            $display("FAIL restore_kill: got full=%0b id=%0d, required full=0 id=0", ck_full, ck_id); n_fail++;
        end
        ck_save = 1; tick(); clr_req();
        n_tests++;
        if (ck_id !== 2'd1) begin $display("FAIL kill_freed_1: got %0d, required 1", ck_id); n_fail++; end
        ck_save = 1; ck_release = 1; ck_rel_id = 1; tick(); clr_req();
        n_tests++;
        if (ck_id !== 2'd2) begin $display("FAIL save_beats_release: got %0d, required 2", ck_id); n_fail++; end
        ck_restore = 1; ck_res_id = 0; ck_kill_mask = 4'b1111; tick(); clr_req();
        n_tests++;
        if (ck_id !== 2'd0 || ck_full !== 1'b0) begin
            $display("FAIL alloc_cleanup: got id=%0d full=%0b, required id=0 full=0", ck_id, ck_full); n_fail++;
        end
    endtask

    task automatic test_flush();
        ren_en = 1; ren_reg = 3; ren_tag = 5; tick(); clr_req();
        ren_en = 1; ren_reg = 9; ren_tag = 7; ck_save = 1; tick(); clr_req(); set_rd(3, 9);
        n_tests++;
        if (rd_tag !== 8'h75) begin $display("FAIL pre_flush_tags: got %h, required 75", rd_tag); n_fail++; end
        flush_all = 1; cmt_en = 1; cmt_reg = 3; cmt_tag = 5; cmt_val = 32'h10;
        ren_en = 1; ren_reg = 4; ren_tag = 1;
        tick(); clr_req(); set_rd(3, 9);
        n_tests++;
        if (rd_tag !== 8'h00 || rd_val[31:0] !== 32'h10) begin
            $display("FAIL flush_x3_x9: got tags=%h x3val=%h, required tags=00 x3val=10", rd_tag, rd_val[31:0]); n_fail++;
        end
        set_rd(4, 7);
        n_tests++;
        if (rd_tag !== 8'h00) begin $display("FAIL flush_x4_x7: got %h, required 00", rd_tag); n_fail++; end
        n_tests++;
        if (ck_id !== 2'd0 || ck_full !== 1'b0) begin
            $display("FAIL flush_ck: got id=%0d full=%0b, required id=0 full=0", ck_id, ck_full); n_fail++;
        end
    endtask

    task automatic test_hold_x0();
        ren_en = 1; ren_reg = 2; ren_tag = 9; tick(); clr_req();
        ck_save = 1; tick(); clr_req();
        rdy = 0;
        ren_en = 1; ren_reg = 2; ren_tag = 1;
        cmt_en = 1; cmt_reg = 2; cmt_tag = 9; cmt_val = 32'h99;
        ck_save = 1; ck_release = 1; ck_rel_id = 0;
        ck_restore = 1; ck_res_id = 0; ck_kill_mask = 4'hF; flush_all = 1;
        repeat (3) tick();
        rdy = 1; clr_req(); set_rd(2, 0);
        n_tests++;
        if (rd_tag[3:0] !== 4'd9 || rd_val[31:0] !== 32'h0) begin
            $display("FAIL hold_x2: got tag=%0d val=%h, required tag=9 val=0", rd_tag[3:0], rd_val[31:0]); n_fail++;
        end
        n_tests++;
        if (ck_id !== 2'd1 || ck_full !== 1'b0) begin
            $display("FAIL hold_ck: got id=%0d full=%0b, required id=1 full=0", ck_id, ck_full); n_fail++;
        end
        ren_en = 1; ren_reg = 0; ren_tag = 3;
        cmt_en = 1; cmt_reg = 0; cmt_tag = 0; cmt_val = 32'h5A; set_rd(0, 0);
        n_tests++;
        if (rd_tag !== 8'h00 || rd_val !== 64'h0) begin
            $display("FAIL x0_same_cycle: got tag=%h val=%h, required 0", rd_tag, rd_val); n_fail++;
        end
        tick(); clr_req(); set_rd(0, 0);
        n_tests++;
        if (rd_tag !== 8'h00 || rd_val !== 64'h0) begin
            $display("FAIL x0_after: got tag=%h val=%h, required 0", rd_tag, rd_val); n_fail++;
        end
    endtask

    initial begin
        rst = 1; rdy = 1; rd_idx = '0; clr_req();
        tick(); tick();
        test_reset();
        test_rename_commit();
        test_rename_wins();
        test_checkpoint_restore();
        test_ck_alloc();
        test_flush();
        test_hold_x0();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
